vpu_cmd_queue: RTL and testbench
================================

// Module: vpu_cmd_queue
// PURPOSE
//  Host-side command queue directly upstream of the VPU top request interface.
//  Buffers host commands (opcode, dst0, src0-2, imm) in a circular FIFO.
//  Presents them to the VPU with a valid/ready handshake, so the host can post
//  up to DEPTH commands while the VPU is busy.
//  First-word-fall-through; each entry is 128 bits (8 + 5x24).
// PARAMETERS
//  DEPTH      8  number of command entries; power of two, >= 2
//  DEPTH_LG2  3  $clog2(DEPTH); pointer width (count is DEPTH_LG2+1 bits)
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  host_valid_i   in   1   host command valid
//  host_ready_o   out  1   queue can accept a command this cycle
//  host_opcode_i  in   8   command opcode
//  host_dst0_i    in   24  destination operand
//  host_src0_i    in   24  source operand 0
//  host_src1_i    in   24  source operand 1
//  host_src2_i    in   24  source operand 2
//  host_imm_i     in   24  immediate
//  vpu_valid_o    out  1   head command valid, to VPU valid
//  vpu_ready_i    in   1   VPU ready, from VPU ready
//  opcode_o       out  8   head opcode
//  dst0_o         out  24  head dst0
//  src0_o         out  24  head src0
//  src1_o         out  24  head src1
//  src2_o         out  24  head src2
//  imm_o          out  24  head imm
//  level_o        out  DEPTH_LG2+1  entries currently held
//  flush_i        in   1   synchronous flush (only with VPU_CMD_QUEUE_FLUSH_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - wr_ptr, rd_ptr and count cleared to 0; vpu_valid_o=0; level_o=0.
//    - host_ready_o=1; all payload outputs 0.
//    - Storage array is not reset.
//    - Reset mid-operation discards all queued commands; no partial pop.
//  - push = host_valid_i & host_ready_o.
//    - Writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
//  - pop = vpu_valid_o & vpu_ready_i.
//    - Increments rd_ptr modulo DEPTH.
//  - Pointers wrap from DEPTH-1 to 0 with no gap.
//  - count: +1 on push only, -1 on pop only, unchanged on push & pop.
//  - host_ready_o = (count != DEPTH), from registered count.
//  - vpu_valid_o = (count != 0).
//  - Payload outputs = mem[rd_ptr] when vpu_valid_o=1, else forced to 0.
//  - Latency: push into an empty queue gives vpu_valid_o=1 the next cycle.
//    There is no same-cycle bypass.
//  - Payload and vpu_valid_o hold stable while vpu_valid_o & !vpu_ready_i.
//  - Full: host_ready_o=0. A simultaneous pop does not let a push in the same
//    cycle (no pass-through); host_ready_o rises the cycle after the pop.
//  - Empty: vpu_ready_i is ignored; count never underflows or overflows.
//  - Commands are delivered strictly in order, each exactly once.
// CONFIGURATION
//  - VPU_CMD_QUEUE_FLUSH_EN defined: flush_i port exists.
//    - flush_i=1 at a clock edge sets pointers and count to 0.
//    - Any push or pop in that cycle is discarded.
//    - vpu_valid_o=0 and host_ready_o=1 from the next cycle.
//  - VPU_CMD_QUEUE_FLUSH_EN undefined: flush_i port absent; queue empties
//    only by popping or by reset.
// TESTING
//  - Single push: opcode=0x12, src0=0x000100; vpu_ready_i=0 ->
//    vpu_valid_o=1 one cycle later; outputs hold until vpu_ready_i=1;
//    level_o goes 1->0.
//  - Fill: 8 pushes with opcode=1..8, vpu_ready_i=0 -> host_ready_o=0 after
//    the 8th; a 9th push is not accepted; level_o=8.
//  - Full with push and pop in the same cycle -> only the pop occurs;
//    level_o=7, then host_ready_o=1.
//  - Wrap: 20 pushes interleaved with random vpu_ready_i ->
//    opcodes 1..20 emerge in order with no loss or duplication.
//  - Async reset with level_o=5 -> vpu_valid_o=0, level_o=0, host_ready_o=1
//    immediately.
//  - With VPU_CMD_QUEUE_FLUSH_EN: level_o=3 and flush_i coincident with a
//    push -> level_o=0 next cycle; the pushed command never appears.

Source files
------------

// File: rtl/vpu_cmd_queue_if.sv
// rtl/vpu_cmd_queue_if.sv - host/VPU command handshake bundle for vpu_cmd_queue
interface vpu_cmd_queue_if #(
  parameter int DEPTH_LG2 = 3
);
  logic                 host_valid_i;
  logic                 host_ready_o;
  logic [7:0]           host_opcode_i;
  logic [23:0]          host_dst0_i;
  logic [23:0]          host_src0_i;
  logic [23:0]          host_src1_i;
  logic [23:0]          host_src2_i;
  logic [23:0]          host_imm_i;
  logic                 vpu_valid_o;
  logic                 vpu_ready_i;
  logic [7:0]           opcode_o;
  logic [23:0]          dst0_o;
  logic [23:0]          src0_o;
  logic [23:0]          src1_o;
  logic [23:0]          src2_o;
  logic [23:0]          imm_o;
  logic [DEPTH_LG2:0]   level_o;

  // Host and VPU side as seen from outside the queue
  modport master (
    output host_valid_i, host_opcode_i, host_dst0_i, host_src0_i,
           host_src1_i, host_src2_i, host_imm_i, vpu_ready_i,
    input  host_ready_o, vpu_valid_o, opcode_o, dst0_o, src0_o,
           src1_o, src2_o, imm_o, level_o
  );

  // The queue itself
  modport slave (
    input  host_valid_i, host_opcode_i, host_dst0_i, host_src0_i,
           host_src1_i, host_src2_i, host_imm_i, vpu_ready_i,
    output host_ready_o, vpu_valid_o, opcode_o, dst0_o, src0_o,
           src1_o, src2_o, imm_o, level_o
  );
endinterface

// File: rtl/vpu_cmd_queue.sv
// rtl/vpu_cmd_queue.sv - FWFT host command FIFO feeding the VPU; optional flush via VPU_CMD_QUEUE_FLUSH_EN
module vpu_cmd_queue #(
  parameter int DEPTH     = 8,
  parameter int DEPTH_LG2 = 3
) (
  input  logic clk,
  input  logic rst_n,
`ifdef VPU_CMD_QUEUE_FLUSH_EN
  input  logic flush_i,
`endif
  vpu_cmd_queue_if.slave bus
);

  localparam int                 ENTRY_W  = 128;
  localparam logic [DEPTH_LG2:0] CNT_FULL = (DEPTH_LG2 + 1)'(DEPTH);

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [DEPTH_LG2-1:0] wr_ptr;
  logic [DEPTH_LG2-1:0] rd_ptr;
  logic [DEPTH_LG2:0]   count;
  logic                 push;
  logic                 pop;
  logic                 flush;
  logic [ENTRY_W-1:0]   head;

`ifdef VPU_CMD_QUEUE_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Ready/valid come straight from the registered count, so a pop while full
  // cannot admit a push in the same cycle.
  assign bus.host_ready_o = (count != CNT_FULL);
  assign bus.vpu_valid_o  = (count != '0);
  assign bus.level_o      = count;

  assign push = bus.host_valid_i & bus.host_ready_o;
  assign pop  = bus.vpu_valid_o & bus.vpu_ready_i;

  // Head entry is only exposed while valid so idle payload reads as zero
  assign head = bus.vpu_valid_o ? mem[rd_ptr] : '0;
  assign {bus.opcode_o, bus.dst0_o, bus.src0_o,
          bus.src1_o, bus.src2_o, bus.imm_o} = head;

  // Command storage; deliberately not reset, pointers/count define validity
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= {bus.host_opcode_i, bus.host_dst0_i, bus.host_src0_i,
                      bus.host_src1_i, bus.host_src2_i, bus.host_imm_i};
    end
  end

  // Pointer and occupancy tracking; flush overrides any push/pop that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_cmd_queue.sv
// tb/tb_vpu_cmd_queue.sv - randomized self-checking bench for vpu_cmd_queue against a queue model
module tb_vpu_cmd_queue;

  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  logic flush;

  int checks;
  int errors;

  logic [127:0] model_q [$];
  logic [7:0]   popped  [$];

  vpu_cmd_queue_if #(.DEPTH_LG2(3)) bus ();

  vpu_cmd_queue #(.DEPTH(DEPTH), .DEPTH_LG2(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef VPU_CMD_QUEUE_FLUSH_EN
    .flush_i (flush),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd_cmd(input logic [7:0] op);
    logic [23:0] f [5];
    for (int i = 0; i < 5; i++) f[i] = 24'($urandom);
    return {op, f[0], f[1], f[2], f[3], f[4]};
  endfunction

  function automatic logic [127:0] dut_head();
    return {bus.opcode_o, bus.dst0_o, bus.src0_o, bus.src1_o, bus.src2_o, bus.imm_o};
  endfunction

  task automatic check_outputs(input string phase);
    logic [127:0] exp_head;
    exp_head = (model_q.size() != 0) ? model_q[0] : '0;
    check({phase, "_level"}, 128'(bus.level_o), 128'(model_q.size()));
    check({phase, "_valid"}, 128'(bus.vpu_valid_o), 128'(model_q.size() != 0));
    check({phase, "_ready"}, 128'(bus.host_ready_o), 128'(model_q.size() != DEPTH));
    check({phase, "_head"}, dut_head(), exp_head);
  endtask

  // One clock: check at negedge, drive, then apply the model after the edge
  task automatic step(input string phase, input logic hv, input logic [127:0] d,
                      input logic vr, input logic fl);
    logic push_ok;
    logic pop_ok;
    @(negedge clk);
    check_outputs(phase);
    bus.host_valid_i = hv;
    {bus.host_opcode_i, bus.host_dst0_i, bus.host_src0_i,
     bus.host_src1_i, bus.host_src2_i, bus.host_imm_i} = d;
    bus.vpu_ready_i = vr;
    flush = fl;
    push_ok = hv && (model_q.size() != DEPTH);
    pop_ok  = vr && (model_q.size() != 0);
    @(posedge clk);
    #1;
`ifdef VPU_CMD_QUEUE_FLUSH_EN
    if (fl) begin
      model_q.delete();
    end else begin
`else
    begin
`endif
      if (pop_ok) begin
        popped.push_back(model_q[0][127:120]);
        void'(model_q.pop_front());
      end
      if (push_ok) model_q.push_back(d);
    end
    bus.host_valid_i = 1'b0;
    bus.vpu_ready_i  = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input string phase, input logic vr);
    step(phase, 1'b0, '0, vr, 1'b0);
  endtask

  initial begin
    logic [127:0] cmd;
    int pushed;
    int cyc;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.host_valid_i = 1'b0;
    bus.vpu_ready_i  = 1'b0;
    {bus.host_opcode_i, bus.host_dst0_i, bus.host_src0_i,
     bus.host_src1_i, bus.host_src2_i, bus.host_imm_i} = '0;

    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push, held while VPU stalls, then popped
    cmd = {8'h12, 24'h0, 24'h000100, 72'h0};
    step("single_push", 1'b1, cmd, 1'b0, 1'b0);
    check("single_valid_next", 128'(bus.vpu_valid_o), 128'(1));
    check("single_opcode", 128'(bus.opcode_o), 128'(8'h12));
    check("single_src0", 128'(bus.src0_o), 128'(24'h000100));
    idle("single_hold", 1'b0);
    idle("single_hold", 1'b0);
    idle("single_pop", 1'b1);
    check("single_level_after_pop", 128'(bus.level_o), 128'(0));

    // Fill with opcodes 1..8, then attempt a 9th push
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, rnd_cmd(8'(i)), 1'b0, 1'b0);
    check("fill_level", 128'(bus.level_o), 128'(8));
    check("fill_ready", 128'(bus.host_ready_o), 128'(0));
    step("fill_ninth", 1'b1, rnd_cmd(8'h09), 1'b0, 1'b0);
    check("ninth_rejected_level", 128'(bus.level_o), 128'(8));

    // Push and pop while full: only the pop happens
    step("full_pushpop", 1'b1, rnd_cmd(8'hAA), 1'b1, 1'b0);
    check("full_pushpop_level", 128'(bus.level_o), 128'(7));
    check("full_pushpop_ready", 128'(bus.host_ready_o), 128'(1));

    // Drain, confirming the fill order 2..8
    popped.delete();
    for (int i = 0; i < 10; i++) idle("drain", 1'(i % 2));
    for (int i = 0; i < 7; i++) idle("drain2", 1'b1);
    check("drain_count", 128'(popped.size()), 128'(7));
    for (int i = 0; i < popped.size() && i < 7; i++)
      check("drain_order", 128'(popped[i]), 128'(i + 2));

    // Wrap: 20 pushes with random VPU ready; opcodes must emerge 1..20 in order
    popped.delete();
    pushed = 0;
    cyc = 0;
    while ((pushed < 20 || model_q.size() != 0) && cyc < 400) begin
      logic hv;
      hv = (pushed < 20) && ($urandom_range(0, 3) != 0);
      if (hv && model_q.size() != DEPTH) begin
        step("wrap", 1'b1, rnd_cmd(8'(pushed + 1)), 1'($urandom_range(0, 1)), 1'b0);
        pushed++;
      end else begin
        step("wrap", 1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
      end
      cyc++;
    end
    check("wrap_pushed", 128'(pushed), 128'(20));
    check("wrap_popped", 128'(popped.size()), 128'(20));
    for (int i = 0; i < popped.size() && i < 20; i++)
      check("wrap_order", 128'(popped[i]), 128'(i + 1));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
`ifdef VPU_CMD_QUEUE_FLUSH_EN
      step("random", 1'($urandom_range(0, 1)), rnd_cmd(8'($urandom)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
`else
      step("random", 1'($urandom_range(0, 1)), rnd_cmd(8'($urandom)),
           1'($urandom_range(0, 1)), 1'b0);
`endif
    end

    // Async reset with five entries held
    for (int i = 0; i < 20 && model_q.size() != 0; i++) idle("pre_reset_drain", 1'b1);
    for (int i = 0; i < 5; i++) step("pre_reset_fill", 1'b1, rnd_cmd(8'(8'h40 + i)), 1'b0, 1'b0);
    check("pre_reset_level", 128'(bus.level_o), 128'(5));
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    check("async_reset_valid", 128'(bus.vpu_valid_o), 128'(0));
    check("async_reset_level", 128'(bus.level_o), 128'(0));
    check("async_reset_ready", 128'(bus.host_ready_o), 128'(1));
    check("async_reset_head", dut_head(), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_reset", 1'b1);
    idle("post_reset", 1'b0);

`ifdef VPU_CMD_QUEUE_FLUSH_EN
    // Flush coincident with a push: pushed command never appears
    for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, rnd_cmd(8'(8'h60 + i)), 1'b0, 1'b0);
    check("pre_flush_level", 128'(bus.level_o), 128'(3));
    popped.delete();
    step("flush", 1'b1, rnd_cmd(8'h77), 1'b0, 1'b1);
    check("flush_level", 128'(bus.level_o), 128'(0));
    check("flush_valid", 128'(bus.vpu_valid_o), 128'(0));
    check("flush_ready", 128'(bus.host_ready_o), 128'(1));
    for (int i = 0; i < 3; i++) idle("post_flush", 1'b1);
    check("flush_nothing_popped", 128'(popped.size()), 128'(0));
`endif

    idle("final", 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
